pixel_histogram_unit: RTL
=========================

PIXEL_HISTOGRAM_UNIT -- requirements
Module: pixel_histogram_unit

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Clock  in  1  system clock (50 MHz); all state changes on posedge.
REQ-003 Resetn  in  1  asynchronous active-low reset.
REQ-004 Enable  in  1  stage enable, driven from the top-level LCD enable; low flushes the pipeline.
REQ-005 Frame_start  in  1  single-cycle pulse on the LTM_VD falling edge (frame boundary).
REQ-006 Pixel_valid  in  1  qualifies R_in/G_in/B_in; driven by the filter-pipe output read strobe.
REQ-007 R_in, G_in, B_in  in  8 each  filtered pixel components.
REQ-008 address  in  5  Avalon-MM word address.
REQ-009 chipselect, read, write  in  1 each  Avalon-MM slave controls.
REQ-010 writedata  in  32  Avalon-MM write data.
REQ-011 readdata  out  32  Avalon-MM read data.
REQ-012 irq  out  1  level interrupt, frame histogram ready.

Function
REQ-013 Luma SHALL be Y = (R_in + 2*G_in + B_in) >> 2, computed in 10-bit arithmetic and truncated to 8 bits.
REQ-014 Bin index SHALL be Y[7:4], giving 16 bins.
REQ-015 The pipeline SHALL have two stages: S1 registers the bin index, valid and bank tag; S2 increments the tagged bin counter.
REQ-016 A pixel sampled in cycle N SHALL appear in its counter at cycle N+2.
REQ-017 There SHALL be two banks of 16 counters, 20 bits each: one ACTIVE (accumulating) and one PUBLISHED (readable).
REQ-018 Counters SHALL saturate at 0xFFFFF and never wrap.
REQ-019 The control FSM SHALL have three states: IDLE, ARM and RUN.
- IDLE: no counting. Moves to ARM when ctrl.acc_en = 1 and Enable = 1.
- ARM: waits for Frame_start. On Frame_start, clears the ACTIVE bank and goes to RUN, without publishing (the first frame is partial).
- RUN: counts valid pixels. On Frame_start, swaps banks, clears the new ACTIVE bank in the same cycle, sets status.ready, and increments frame_cnt (16 bits, wraps).
- Any state: Enable = 0 or ctrl.acc_en = 0 returns the FSM to IDLE and clears S1/S2 valids. Banks and the published data are retained.
REQ-020 A pixel valid in the same cycle as Frame_start SHALL count toward the new frame. Pixels already in S1/S2 SHALL complete into the bank they were tagged with.
REQ-021 Pixel_valid SHALL be ignored in IDLE and ARM.
REQ-022 Register map, read with registered readdata and 1-cycle latency, no waitrequest:
- Addresses 0-15: PUBLISHED bin counts, zero-extended.
- Address 16: status; bit0 = ready, bits 3:2 = FSM state.
- Address 17: frame_cnt.
- Address 18: ctrl; bit0 = acc_en, bit1 = irq_en.
- Other addresses read 0.
REQ-023 Writes SHALL require chipselect & write. Address 18 loads ctrl bits 1:0. Address 16 with writedata[0] = 1 clears ready. All other writes are ignored.
REQ-024 A ready set and a ready clear in the same cycle SHALL resolve to set.
REQ-025 readdata SHALL hold its last value when no read is in progress.

Reset
REQ-026 On Resetn low, the following SHALL be 0: all counters in both banks, FSM (IDLE), bank select, S1/S2 valids, ready, frame_cnt, ctrl, readdata and irq.
REQ-027 Reset SHALL take effect immediately, mid-frame included. No partial histogram SHALL be published afterwards.

Configuration
REQ-028 Macro HIST_IRQ_EN SHALL control the interrupt feature.
- Defined: irq = ready & ctrl.irq_en, registered.
- Undefined: irq is tied 0, ctrl bit1 is not stored and reads 0, and software polls status.ready.

Verification
REQ-029 Reset, acc_en = 1, then Frame_start, 100 pixels (R,G,B) = (255,255,255), then Frame_start -> bin15 = 100, other bins 0, ready = 1, frame_cnt = 1.
REQ-030 Pixels (16,16,16) and (0,32,0) in one frame -> both land in bin1 (Y = 16), bin1 = 2.
REQ-031 Pixel_valid asserted in the same cycle as the second Frame_start -> that pixel is absent from the published bank and appears in the next frame's histogram.
REQ-032 Pixels before the first Frame_start after acc_en -> not counted, and ready stays 0 until the second Frame_start.
REQ-033 With HIST_IRQ_EN defined and irq_en = 1, a frame swap -> irq rises one cycle after ready. A write of 1 to address 16 -> irq = 0 the next cycle. With the macro undefined, irq stays 0 throughout.
REQ-034 Resetn pulsed low mid-frame with 500 counts pending -> all reads return 0 and the FSM reads IDLE.

Source files
------------

// File: rtl/pixel_histogram_unit_if.sv
// Avalon-MM slave bus for the pixel histogram unit: word address, registered read data.
interface pixel_histogram_unit_if;
   logic [4:0]  address;
   logic        chipselect;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, chipselect, read, write, writedata, input readdata);
   modport slave  (input address, chipselect, read, write, writedata, output readdata);
endinterface

// File: rtl/pixel_histogram_unit.sv
// Double-banked 16-bin luma histogram with an Avalon-MM register window.
// Optional HIST_IRQ_EN adds a registered, maskable "frame ready" interrupt.
module pixel_histogram_unit (
   input  logic                    Clock,
   input  logic                    Resetn,
   input  logic                    Enable,
   input  logic                    Frame_start,
   input  logic                    Pixel_valid,
   input  logic [7:0]              R_in,
   input  logic [7:0]              G_in,
   input  logic [7:0]              B_in,
   pixel_histogram_unit_if.slave   bus,
   output logic                    irq
);
   typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2} state_t;

   localparam logic [19:0] CNT_MAX = 20'hFFFFF;

   state_t      state_q, state_d;
   logic        bank_sel;
   logic        s1_vld, s1_tag;
   logic [3:0]  s1_bin;
   logic        ready;
   logic [15:0] frame_cnt;
   logic        acc_en, irq_en;
   logic [19:0] cnt [2][16];

   logic        flush, arm_start, swap, accept, tag, clr_en;
   logic        wr_en, rd_en, ready_clr;
   logic [9:0]  y10;
   logic [31:0] rd_mux;
   logic        unused_bits;

   assign y10 = {2'b0, R_in} + {1'b0, G_in, 1'b0} + {2'b0, B_in};
   assign unused_bits = ^{bus.writedata[31:1], y10[5:0]};

   assign flush     = !Enable || !acc_en;
   assign arm_start = !flush && (state_q == ARM) && Frame_start;
   assign swap      = !flush && (state_q == RUN) && Frame_start;
   assign accept    = !flush && Pixel_valid && ((state_q == RUN) || arm_start);
   // The bank a new pixel belongs to is the one that is ACTIVE after this edge.
   assign tag       = swap ? ~bank_sel : bank_sel;
   assign clr_en    = arm_start || swap;

   assign wr_en     = bus.chipselect && bus.write;
   assign rd_en     = bus.chipselect && bus.read;
   assign ready_clr = wr_en && (bus.address == 5'd16) && bus.writedata[0];

   always_comb begin
      state_d = state_q;
      if (flush) state_d = IDLE;
      else begin
         case (state_q)
            IDLE:    state_d = ARM;
            ARM:     if (Frame_start) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q   <= IDLE;
         bank_sel  <= 1'b0;
         s1_vld    <= 1'b0;
         s1_tag    <= 1'b0;
         s1_bin    <= 4'd0;
         ready     <= 1'b0;
         frame_cnt <= 16'd0;
         acc_en    <= 1'b0;
      end else begin
         state_q <= state_d;
         s1_vld  <= accept;
         s1_tag  <= tag;
         s1_bin  <= y10[9:6];
         if (swap) begin
            bank_sel  <= ~bank_sel;
            frame_cnt <= frame_cnt + 16'd1;
         end
         // A swap in the same cycle as a software clear wins.
         if (swap)           ready <= 1'b1;
         else if (ready_clr) ready <= 1'b0;
         if (wr_en && bus.address == 5'd18) acc_en <= bus.writedata[0];
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      for (genvar i = 0; i < 16; i++) begin : g_bin
         always_ff @(posedge Clock or negedge Resetn) begin
            if (!Resetn)
               cnt[b][i] <= 20'd0;
            else if (clr_en && tag == 1'(b))
               cnt[b][i] <= 20'd0;
            else if (s1_vld && !flush && s1_tag == 1'(b) && s1_bin == 4'(i) && cnt[b][i] != CNT_MAX)
               cnt[b][i] <= cnt[b][i] + 20'd1;
         end
      end
   end

`ifdef HIST_IRQ_EN
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         irq_en <= 1'b0;
         irq    <= 1'b0;
      end else begin
         if (wr_en && bus.address == 5'd18) irq_en <= bus.writedata[1];
         irq <= ready && irq_en;
      end
   end
`else
   assign irq_en = 1'b0;
   assign irq    = 1'b0;
`endif

   always_comb begin
      rd_mux = 32'd0;
      case (bus.address)
         5'd16:   rd_mux = {28'd0, state_q, 1'b0, ready};
         5'd17:   rd_mux = {16'd0, frame_cnt};
         5'd18:   rd_mux = {30'd0, irq_en, acc_en};
         default: if (!bus.address[4]) rd_mux = {12'd0, cnt[~bank_sel][bus.address[3:0]]};
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn)    bus.readdata <= 32'd0;
      else if (rd_en) bus.readdata <= rd_mux;
   end
endmodule
